nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 154 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. One 4-bit carry-lookahead slice is reused
//   across the operand, one nibble per clock, with the inter-nibble carry
//   held in a register. Operands and results move over valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept operands (IDLE only)
//   in_a/in_b  WIDTH-bit operands
//   in_cin     carry into nibble 0
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   out_sum    A+B+cin modulo 2^WIDTH
//   out_cout   carry out of the MSB
//   out_ovf    signed overflow
//   busy       operation in progress or result pending
//
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [IDXW-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            carry_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic [3:0]      sum_nib_reg [NIB];

  // Operand registers viewed as nibble arrays so the active slice is a
  // plain array index by idx_reg.
  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign out_sum[4*gi +: 4] = sum_nib_reg[gi];
    end
  endgenerate

  // 4-bit lookahead slice. Every carry is a flat sum of products of the
  // generate/propagate terms and the carry-in; no carry feeds another.
  logic [3:0] cur_a;
  logic [3:0] cur_b;
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] s;

  always_comb begin
    cur_a = a_nib[idx_reg];
    cur_b = b_nib[idx_reg];
    p     = cur_a ^ cur_b;
    g     = cur_a & cur_b;
    c[0]  = carry_reg;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s     = p ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < NIB; i++) begin
        sum_nib_reg[i] <= 4'h0;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          sum_nib_reg[idx_reg] <= s;
          carry_reg            <= c[4];
          if (idx_reg == LAST_IDX) begin
            // Top nibble: c4 is the MSB carry-out and c3 the carry into
            // the sign bit, so their XOR flags signed overflow.
            cout_reg  <= c[4];
            ovf_reg   <= c[3] ^ c[4];
            idx_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode the state register only; no path from in_valid
  // or out_ready.
  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // 16-bit instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  // 4-bit instance
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  in_a4 = '0;
  logic [3:0]  in_b4 = '0;
  logic        in_cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [3:0]  out_sum4;
  logic        out_cout4;
  logic        out_ovf4;
  logic        busy4;

  int errs = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4),
    .busy(busy4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the 16-bit instance: the result is plain integer
  // addition, and timing is "busy for NIB cycles, then hold until taken".
  logic [16:0] m_full;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_sum = '0;
  logic        m_cout = 1'b0;
  logic        m_ovf = 1'b0;

  assign m_full = {1'b0, in_a} + {1'b0, in_b} + {16'd0, in_cin};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (in_valid) begin
      m_left <= NIB;
      m_sum  <= m_full[15:0];
      m_cout <= m_full[16];
      m_ovf  <= (in_a[15] == in_b[15]) && (m_full[15] != in_a[15]);
    end
  end

  // Compare process: every cycle, control flags; data whenever valid.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_left == 0) && !m_done});
      chk("busy", {31'd0, busy}, {31'd0, (m_left != 0) || m_done});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
      if (m_done) begin
        chk("out_sum", {16'd0, out_sum}, {16'd0, m_sum});
        chk("out_cout", {31'd0, out_cout}, {31'd0, m_cout});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, m_ovf});
      end
    end
  end

  // Directed 16-bit transaction with hand-computed expectations.
  task automatic do16(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input int hold, input logic [15:0] es,
                      input logic ec, input logic eo);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, NIB);
    for (int i = 0; i < hold; i++) begin
      // Operands presented while DONE must be ignored.
      if (i == 1) begin
        in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({nm, "_held_sum"}, {16'd0, out_sum}, {16'd0, es});
      chk({nm, "_held_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    chk({nm, "_sum"}, {16'd0, out_sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    $display("txn %s: a=%h b=%h cin=%0d sum=%h cout=%0d ovf=%0d lat=%0d",
             nm, a, b, cin, out_sum, out_cout, out_ovf, n);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw;
    logic [4:0] full4;
    logic eovf4;

    // Reset asserted mid-clock-low takes effect immediately.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    do16("basic", 16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
    do16("fullprop", 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
    do16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    do16("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1);
    do16("backpressure", 16'h00F0, 16'h0F10, 1'b0, 5, 16'h1000, 1'b0, 1'b0);

    // Abort: reset after two RUN cycles, no result may appear.
    @(negedge clk);
    in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("abort_no_valid", {31'd0, saw}, 32'd0);
    $display("txn abort: a=ffff b=0001 aborted, out_valid seen=%0d", saw);
    do16("after_abort", 16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0);

    // Randomized traffic with random backpressure, checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0: in_a = 16'hFFFF;
        1: in_a = 16'h8000;
        2: in_a = 16'h7FFF;
        default: in_a = 16'($urandom);
      endcase
      in_b   = 16'($urandom);
      in_cin = 1'($urandom);
      if (in_valid && in_ready)
        $display("txn rand: a=%h b=%h cin=%0d", in_a, in_b, in_cin);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;

    // WIDTH=4 instance: every (a, b, cin) combination.
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      in_a4 = v[3:0]; in_b4 = v[7:4]; in_cin4 = v[8];
      in_valid4 = 1'b1; out_ready4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 10) begin
        @(negedge clk);
        n++;
      end
      full4 = {1'b0, in_a4} + {1'b0, in_b4} + {4'd0, in_cin4};
      eovf4 = (in_a4[3] == in_b4[3]) && (full4[3] != in_a4[3]);
      chk("w4_latency", n, 32'd1);
      chk("w4_sum", {28'd0, out_sum4}, {28'd0, full4[3:0]});
      chk("w4_cout", {31'd0, out_cout4}, {31'd0, full4[4]});
      chk("w4_ovf", {31'd0, out_ovf4}, {31'd0, eovf4});
      $display("txn w4: a=%h b=%h cin=%0d sum=%h cout=%0d ovf=%0d",
               in_a4, in_b4, in_cin4, out_sum4, out_cout4, out_ovf4);
    end
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("w4_idle", {31'd0, in_ready4}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
